// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and widths for the CPU step/run clock-enable controller.
package cpu_step_ctrl_pkg;

    localparam int unsigned DIV_W      = 32;
    localparam int unsigned STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Divider/button inputs and CPU-enable outputs of the step controller.
interface cpu_step_ctrl_if;
    import cpu_step_ctrl_pkg::*;

    logic [DIV_W-1:0]      clk_div_counter;
    logic                  step_btn;
    logic                  mode_run;
    logic                  cpu_en;
    logic                  step_btn_db;
    logic                  mode_run_db;
    logic [STEP_CNT_W-1:0] step_count;

    modport master (
        output clk_div_counter, step_btn, mode_run,
        input  cpu_en, step_btn_db, mode_run_db, step_count
    );

    modport slave (
        input  clk_div_counter, step_btn, mode_run,
        output cpu_en, step_btn_db, mode_run_db, step_count
    );

endinterface

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Two-flop synchronizer plus tick-sampled debounce counter for one raw input.
module btn_debounce #(
    parameter int unsigned DB_COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic db
);

    localparam int unsigned CNT_W = $clog2(DB_COUNT);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Accept a change only after DB_COUNT consecutive differing ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (tick) begin
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DB_COUNT - 1)) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU advance-enable controller: debounced single-step pulses or periodic run
// pulses derived from the free-running clock-divider count.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned TICK_BIT = 16,
    parameter int unsigned DB_COUNT = 4,
    parameter int unsigned RUN_BIT  = 24
) (
    input  logic            clk,
    input  logic            reset,
    cpu_step_ctrl_if.slave  bus
);

    logic                  r_tick_bit_d;
    logic                  r_run_bit_d;
    logic                  w_db_tick;
    logic                  w_run_tick;
    logic                  w_step_db;
    logic                  w_mode_db;
    logic                  w_step_rise;
    logic                  r_step_db_d;
    state_e                r_state;
    logic                  r_cpu_en;
    logic [STEP_CNT_W-1:0] r_step_count;

    // Edge flops follow the divider even in reset so no tick fires right after it.
    always_ff @(posedge clk) begin
        r_tick_bit_d <= bus.clk_div_counter[TICK_BIT];
        r_run_bit_d  <= bus.clk_div_counter[RUN_BIT];
    end

    assign w_db_tick  = bus.clk_div_counter[TICK_BIT] & ~r_tick_bit_d;
    assign w_run_tick = bus.clk_div_counter[RUN_BIT] & ~r_run_bit_d;

    btn_debounce #(.DB_COUNT(DB_COUNT)) u_step_db (
        .clk   (clk),
        .reset (reset),
        .tick  (w_db_tick),
        .raw   (bus.step_btn),
        .db    (w_step_db)
    );

    btn_debounce #(.DB_COUNT(DB_COUNT)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .tick  (w_db_tick),
        .raw   (bus.mode_run),
        .db    (w_mode_db)
    );

    assign w_step_rise = w_step_db & ~r_step_db_d;

    // Mode FSM; run mode always takes priority over a coincident step edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cpu_en     <= 1'b0;
            r_step_db_d  <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_cpu_en    <= 1'b0;
            r_step_db_d <= w_step_db;
            if (r_cpu_en) begin
                r_step_count <= r_step_count + STEP_CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_mode_db) begin
                        r_state <= ST_RUN;
                    end else if (w_step_rise) begin
                        r_cpu_en <= 1'b1;
                        r_state  <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (w_mode_db) begin
                        r_state <= ST_RUN;
                    end else if (!w_step_db) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!w_mode_db) begin
                        r_state <= w_step_db ? ST_WAIT_REL : ST_IDLE;
                    end else if (w_run_tick) begin
                        r_cpu_en <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_en      = r_cpu_en;
    assign bus.step_btn_db = w_step_db;
    assign bus.mode_run_db = w_mode_db;
    assign bus.step_count  = r_step_count;

endmodule
